// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART types, default parameters and parity helper.
// Rev    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int unsigned c_DEF_DATA_WIDTH = 8;
    localparam int unsigned c_DEF_CLK_DIV    = 16;
    localparam int unsigned c_DEF_STOP_BITS  = 1;
    localparam int unsigned c_MAX_DATA_WIDTH = 9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_e;

    // Callers zero-extend narrower words; zeros do not affect the XOR.
    function automatic logic parity_even(input logic [c_MAX_DATA_WIDTH-1:0] data);
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module : uart_baud_cnt
// Brief  : Loadable down-counter; o_tick is high while enabled and at zero.
// Rev    : 1.0 - initial release
// ============================================================================
module uart_baud_cnt #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_tick
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_tick = i_en && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module : uart_tx
// Brief  : Valid/ready fed UART transmitter: start, LSB-first data, optional
//          even parity (`UART_TX_PARITY_EN), stop bits. tx_o is registered.
// Rev    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DataWidth = c_DEF_DATA_WIDTH,
    parameter int unsigned ClkDiv    = c_DEF_CLK_DIV,
    parameter int unsigned StopBits  = c_DEF_STOP_BITS
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DataWidth-1:0] data_i,
    output logic                 tx_o,
    output logic                 busy_o
);

    localparam int unsigned c_CNT_W  = $clog2(ClkDiv);
    localparam int unsigned c_IDX_W  = $clog2(DataWidth);
    localparam int unsigned c_STOP_W = $clog2(StopBits * ClkDiv);

    localparam logic [c_CNT_W-1:0]  c_BIT_LOAD  = c_CNT_W'(ClkDiv - 1);
    localparam logic [c_STOP_W-1:0] c_STOP_LOAD = c_STOP_W'(StopBits * ClkDiv - 1);
    localparam logic [c_IDX_W-1:0]  c_LAST_IDX  = c_IDX_W'(DataWidth - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'(IDLE);
    localparam logic [2:0] c_ST_START = 3'(START);
    localparam logic [2:0] c_ST_DATA  = 3'(DATA);
    localparam logic [2:0] c_ST_STOP  = 3'(STOP);
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_ST_PARITY     = 3'(PARITY);
    localparam logic [2:0] c_ST_AFTER_DATA = c_ST_PARITY;
`else
    localparam logic [2:0] c_ST_AFTER_DATA = c_ST_STOP;
`endif

    logic [2:0]           r_state;
    logic [DataWidth-1:0] r_shift;
    logic [c_IDX_W-1:0]   r_idx;
    logic                 r_tx;
    logic                 r_busy;
`ifdef UART_TX_PARITY_EN
    logic                 r_par;
`endif

    logic w_hs;
    logic w_bit_phase;
    logic w_bit_tick;
    logic w_bit_load;
    logic w_stop_tick;
    logic w_stop_load;
    logic w_last_bit;
    logic w_tx_next;

    assign ready_o = reset_ni && (r_state == c_ST_IDLE);
    assign w_hs    = valid_i && ready_o;

`ifdef UART_TX_PARITY_EN
    assign w_bit_phase = (r_state == c_ST_START) || (r_state == c_ST_DATA) ||
                         (r_state == c_ST_PARITY);
    assign w_stop_load = w_bit_tick && (r_state == c_ST_PARITY);
`else
    assign w_bit_phase = (r_state == c_ST_START) || (r_state == c_ST_DATA);
    assign w_stop_load = w_bit_tick && w_last_bit;
`endif

    assign w_last_bit = (r_state == c_ST_DATA) && (r_idx == c_LAST_IDX);
    // Reload on every bit boundary except the hand-off to the stop counter.
    assign w_bit_load = w_hs || (w_bit_tick && !w_stop_load);

    uart_baud_cnt #(
        .WIDTH (c_CNT_W)
    ) u_bit_cnt (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .i_load     (w_bit_load),
        .i_load_val (c_BIT_LOAD),
        .i_en       (w_bit_phase),
        .o_tick     (w_bit_tick)
    );

    uart_baud_cnt #(
        .WIDTH (c_STOP_W)
    ) u_stop_cnt (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .i_load     (w_stop_load),
        .i_load_val (c_STOP_LOAD),
        .i_en       (r_state == c_ST_STOP),
        .o_tick     (w_stop_tick)
    );

    always_comb begin
        w_tx_next = 1'b1;
        case (r_state)
            c_ST_START:  w_tx_next = 1'b0;
            c_ST_DATA:   w_tx_next = r_shift[0];
`ifdef UART_TX_PARITY_EN
            c_ST_PARITY: w_tx_next = r_par;
`endif
            default:     w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state <= c_ST_IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            // Line and busy flag trail the state by one cycle.
            r_tx   <= w_tx_next;
            r_busy <= (r_state != c_ST_IDLE);
            case (r_state)
                c_ST_IDLE: begin
                    if (w_hs) begin
                        r_shift <= data_i;
                        r_idx   <= '0;
                        r_state <= c_ST_START;
`ifdef UART_TX_PARITY_EN
                        r_par   <= parity_even(c_MAX_DATA_WIDTH'(data_i));
`endif
                    end
                end
                c_ST_START: begin
                    if (w_bit_tick) begin
                        r_state <= c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_tick) begin
                        r_shift <= r_shift >> 1;
                        r_idx   <= r_idx + c_IDX_W'(1);
                        if (w_last_bit) begin
                            r_state <= c_ST_AFTER_DATA;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                c_ST_PARITY: begin
                    if (w_bit_tick) begin
                        r_state <= c_ST_STOP;
                    end
                end
`endif
                c_ST_STOP: begin
                    if (w_stop_tick) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign tx_o   = r_tx;
    assign busy_o = r_busy;

endmodule
`default_nettype wire
